pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, the
// pipeline NOP encoding and default parameter values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // Encoding loaded into IF/ID, ID/EX or MEM/WB whenever a flush or bubble is requested
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  localparam int MAX_WAIT_DEF = 16;
  localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX (register 0 never creates a hazard).
module hazard_detect (
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  output logic       load_use_o
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = (idex_rt_i == id_rs_i);
  assign rt_match_s = id_uses_rt_i && (idex_rt_i == id_rt_i);
  assign load_use_o = idex_memread_i && (idex_rt_i != 5'd0) && (rs_match_s || rt_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze with timeout,
// taken-branch flush and load-use stall, plus a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src_branch,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state_o
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q;

  logic load_use_s;
  logic mem_stall_s;
  logic freeze_s;
  logic run_eval_s;

  hazard_detect u_hazard_detect (
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .load_use_o     (load_use_s)
  );

  assign mem_stall_s = mem_req && !mem_ready;

  // Next-state logic; freeze_s and run_eval_s are mutually exclusive
  always_comb begin
    freeze_s      = 1'b0;
    run_eval_s    = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_s) begin
          freeze_s   = 1'b1;
          wait_cnt_d = WCNT_W'(1);
          if (MAX_WAIT <= 1) begin
            state_d       = ST_HALT;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          run_eval_s = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          freeze_s   = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          // Counter reaching MAX_WAIT on this cycle means MAX_WAIT stalled cycles in a row
          if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
            state_d       = ST_HALT;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          run_eval_s = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_HALT: begin
        freeze_s = 1'b1;
        state_d  = ST_HALT;
      end
      default: begin
        freeze_s      = 1'b1;
        state_d       = ST_HALT;
        mem_timeout_d = 1'b1;
      end
    endcase
  end

  // Pipeline control outputs: freeze beats branch, branch squashes load-use
  always_comb begin
    pc_write      = 1'b1;
    pc_src_branch = 1'b0;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    memwb_bubble  = 1'b0;
    if (freeze_s) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (run_eval_s && ex_branch_taken) begin
      pc_src_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
    end else if (run_eval_s && load_use_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Controller state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_q <= stall_cycles_q;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model of the rules.
module tb_pipe_hazard_ctrl;

  localparam int MW = 16;
  localparam int CW = 6;
  localparam logic [10:0] RUN_DEF = 11'b10111000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = 5'd0, id_rt = 5'd0, idex_rt = 5'd0;
  logic          id_uses_rt = 1'b0, idex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b1;
  logic          pc_write, pc_src_branch, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_bubble, memwb_bubble, mem_timeout;
  logic [CW-1:0] stall_cycles;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_src_branch(pc_src_branch), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .state_o(state_o)
  );

  logic [10:0] obs_v;
  assign obs_v = {pc_write, pc_src_branch, ifid_write, idex_write, exmem_write,
                  ifid_flush, idex_bubble, memwb_bubble, mem_timeout, state_o};

  int total = 0;
  int bad = 0;

  // Model: halted flag, length of the current not-ready run, timeout, stall count
  bit m_halt, n_halt, m_to, n_to;
  int m_wait, n_wait, m_stall, n_stall;
  logic [10:0] exp_v;
  int exp_stall;

  task automatic model_reset();
    m_halt = 1'b0; n_halt = 1'b0; m_to = 1'b0; n_to = 1'b0;
    m_wait = 0; n_wait = 0; m_stall = 0; n_stall = 0;
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mrd, input logic [4:0] xrt, input logic br,
                       input logic req, input logic rdy);
    bit lu, frz;
    logic [7:0] ctl;
    logic [1:0] st;
    @(negedge clk);
    m_halt = n_halt; m_to = n_to; m_wait = n_wait; m_stall = n_stall;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; idex_memread = mrd; idex_rt = xrt;
    ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    lu  = mrd && (xrt != 5'd0) && ((xrt == rs) || (urt && (xrt == rt)));
    frz = m_halt || ((m_wait > 0) ? !rdy : (req && !rdy));
    st  = m_halt ? 2'd2 : ((m_wait > 0) ? 2'd1 : 2'd0);
    ctl = 8'b1011_1000;
    n_halt = m_halt; n_to = m_to; n_wait = m_wait;
    if (frz) begin
      ctl = 8'b0000_0001;
      if (!m_halt) begin
        n_wait = m_wait + 1;
        if (n_wait >= MW) begin
          n_halt = 1'b1;
          n_to   = 1'b1;
        end
      end
    end else begin
      n_wait = 0;
      if (br) ctl = 8'b1111_1110;
      else if (lu) ctl = 8'b0001_1010;
    end
    exp_v     = {ctl, m_to, st};
    exp_stall = m_stall;
    n_stall   = (!ctl[7] && (m_stall < (1 << CW) - 1)) ? m_stall + 1 : m_stall;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_v !== RUN_DEF || stall_cycles !== CW'(0)) begin
      bad++;
      $display("FAIL reset: got %b/%0d want %b/0", obs_v, stall_cycles, RUN_DEF);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_v !== exp_v || pc_write !== 1'b0 || ifid_write !== 1'b0 || idex_bubble !== 1'b1) begin
      bad++;
      $display("FAIL load_use: got %b want %b", obs_v, exp_v);
    end
    apply(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_v !== exp_v || stall_cycles !== CW'(1) || pc_write !== 1'b1) begin
      bad++;
      $display("FAIL load_use_release: got %b/%0d want %b/1", obs_v, stall_cycles, exp_v);
    end
  endtask

  task automatic test_load_use_regs();
    logic [4:0] tbl_rs [4] = '{5'd0, 5'd1, 5'd1, 5'd9};
    logic [4:0] tbl_rt [4] = '{5'd0, 5'd7, 5'd7, 5'd3};
    logic       tbl_u  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] tbl_x  [4] = '{5'd0, 5'd7, 5'd7, 5'd4};
    logic       tbl_pw [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(tbl_rs[i], tbl_rt[i], tbl_u[i], 1'b1, tbl_x[i], 1'b0, 1'b0, 1'b1);
      total++;
      if (obs_v !== exp_v || pc_write !== tbl_pw[i] || stall_cycles !== CW'(exp_stall)) begin
        bad++;
        $display("FAIL lu_regs[%0d]: got %b/%0d want %b/%0d", i, obs_v, stall_cycles, exp_v, exp_stall);
      end
    end
  endtask

  task automatic test_branch_over_load_use();
    apply(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    total++;
    if (obs_v !== exp_v || pc_src_branch !== 1'b1 || ifid_flush !== 1'b1 ||
        idex_bubble !== 1'b1 || pc_write !== 1'b1) begin
      bad++;
      $display("FAIL branch_lu: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      total++;
      if (obs_v !== exp_v || memwb_bubble !== 1'b1 || state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin
        bad++;
        $display("FAIL mem_wait[%0d]: got %b want %b", i, obs_v, exp_v);
      end
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    total++;
    if (obs_v !== exp_v || pc_write !== 1'b1 || stall_cycles !== CW'(3)) begin
      bad++;
      $display("FAIL mem_release: got %b/%0d want %b/3", obs_v, stall_cycles, exp_v);
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_v !== exp_v || state_o !== 2'd0) begin
      bad++;
      $display("FAIL mem_back_run: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_branch_in_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, (i == 2) ? 1'b1 : 1'b0);
      total++;
      if (obs_v !== exp_v || pc_src_branch !== ((i == 2) ? 1'b1 : 1'b0) ||
          ifid_flush !== ((i == 2) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL branch_wait[%0d]: got %b want %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_wait_boundary();
    do_reset();
    for (int i = 0; i < MW; i++) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, (i == MW - 1) ? 1'b1 : 1'b0);
      total++;
      if (obs_v !== exp_v || stall_cycles !== CW'(exp_stall)) begin
        bad++;
        $display("FAIL wait_15[%0d]: got %b/%0d want %b/%0d", i, obs_v, stall_cycles, exp_v, exp_stall);
      end
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_v !== exp_v || mem_timeout !== 1'b0 || state_o !== 2'd0) begin
      bad++;
      $display("FAIL wait_15_run: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < MW; i++) begin
      apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      total++;
      if (obs_v !== exp_v || stall_cycles !== CW'(exp_stall)) begin
        bad++;
        $display("FAIL halt_in[%0d]: got %b/%0d want %b/%0d", i, obs_v, stall_cycles, exp_v, exp_stall);
      end
    end
    for (int i = 0; i < 52; i++) begin
      apply(5'($urandom_range(0, 3)), 5'd1, 1'b1, 1'b1, 5'd1, 1'($urandom), 1'($urandom), 1'b1);
      total++;
      if (obs_v !== exp_v || state_o !== 2'd2 || mem_timeout !== 1'b1 ||
          stall_cycles !== CW'(exp_stall)) begin
        bad++;
        $display("FAIL halted[%0d]: got %b/%0d want %b/%0d", i, obs_v, stall_cycles, exp_v, exp_stall);
      end
    end
    apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (stall_cycles !== CW'((1 << CW) - 1) || obs_v !== exp_v) begin
      bad++;
      $display("FAIL stall_sat: got %0d want %0d", stall_cycles, (1 << CW) - 1);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs_v !== RUN_DEF || stall_cycles !== CW'(0)) begin
      bad++;
      $display("FAIL halt_reset: got %b/%0d want %b/0", obs_v, stall_cycles, RUN_DEF);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (m_halt && ($urandom_range(0, 7) == 0)) do_reset();
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            1'($urandom), ($urandom_range(0, 4) != 0));
      total++;
      if (obs_v !== exp_v || stall_cycles !== CW'(exp_stall)) begin
        bad++;
        $display("FAIL random[%0d]: got %b/%0d want %b/%0d", i, obs_v, stall_cycles, exp_v, exp_stall);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_load_use_regs();
    test_branch_over_load_use();
    test_mem_wait();
    test_branch_in_wait();
    test_wait_boundary();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
